// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : RAW hazard detector tracking in-flight destinations after ID,
//               with forwarding/no-forwarding modes, freeze, flush and stall count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int REG_W    = 4,
  parameter int DEPTH    = 3,
  parameter int LU_DEPTH = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forwarding,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             id_wb_enable,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_is_load,
  input  logic             mem_ready,
  input  logic             flush,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_count
);

  // Entries below LU_DEPTH are the ones a load result cannot yet be forwarded from.
  localparam logic [DEPTH-1:0] c_lu_mask = DEPTH'((1 << LU_DEPTH) - 1);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0]            r_is_load;
  logic [DEPTH-1:0][REG_W-1:0] r_dest;
  logic [CNT_W-1:0]            r_stall_count;

  logic [DEPTH-1:0] w_match;
  logic             w_hazard;
  logic             w_issue;

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign w_match[i] = r_valid[i] &&
                        ((r_dest[i] == src1) || (two_src && (r_dest[i] == src2)));
  end

  always_comb begin
    w_hazard = 1'b0;
    if (!flush) begin
      w_hazard = forwarding ? |(w_match & r_is_load & c_lu_mask) : |w_match;
    end
  end

  assign w_issue = id_wb_enable && !w_hazard && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= '0;
      r_is_load     <= '0;
      r_dest        <= '0;
      r_stall_count <= '0;
    end else if (mem_ready) begin
      r_valid   <= {r_valid[DEPTH-2:0], w_issue};
      r_is_load <= {r_is_load[DEPTH-2:0], id_is_load && w_issue};
      r_dest    <= {r_dest[DEPTH-2:0], id_dest};
      if (w_hazard && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign hazard      = w_hazard;
  assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        forwarding;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic        id_wb_enable;
  logic [3:0]  id_dest;
  logic        id_is_load;
  logic        mem_ready;
  logic        flush;
  logic        hazard;
  logic [15:0] stall_count;
  logic        hazard_s;
  logic [1:0]  stall_count_s;

  int checks;
  int errors;

  hazard_scoreboard #(.REG_W(4), .DEPTH(3), .LU_DEPTH(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .forwarding(forwarding), .src1(src1), .src2(src2),
    .two_src(two_src), .id_wb_enable(id_wb_enable), .id_dest(id_dest),
    .id_is_load(id_is_load), .mem_ready(mem_ready), .flush(flush),
    .hazard(hazard), .stall_count(stall_count)
  );

  // Narrow-counter copy driven by the same stimulus, used for saturation.
  hazard_scoreboard #(.REG_W(4), .DEPTH(3), .LU_DEPTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .forwarding(forwarding), .src1(src1), .src2(src2),
    .two_src(two_src), .id_wb_enable(id_wb_enable), .id_dest(id_dest),
    .id_is_load(id_is_load), .mem_ready(mem_ready), .flush(flush),
    .hazard(hazard_s), .stall_count(stall_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    src1 = 4'd0; src2 = 4'd0; two_src = 1'b0;
    id_wb_enable = 1'b0; id_dest = 4'd0; id_is_load = 1'b0;
    mem_ready = 1'b1; flush = 1'b0;
  endtask

  task automatic do_reset;
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    forwarding = 1'b0;
    do_reset();
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b exp 0", hazard); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", stall_count); end
    checks++; if (stall_count_s !== 2'd0) begin errors++; $display("FAIL reset_count_sat got %0d exp 0", stall_count_s); end
    tick(); tick();
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL idle_hazard got %b exp 0", hazard); end
  endtask

  task automatic test_no_fwd;
    do_reset();
    forwarding = 1'b0;
    id_wb_enable = 1'b1; id_dest = 4'd3;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL nofwd_issue got %b exp 0", hazard); end
    tick();
    id_wb_enable = 1'b0; src1 = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL nofwd_stall%0d got %b exp 1", i, hazard); end
      tick();
    end
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL nofwd_clear got %b exp 0", hazard); end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL nofwd_count got %0d exp 3", stall_count); end
  endtask

  task automatic test_fwd;
    // Load-use on src2 with two_src: exactly one stall.
    do_reset();
    forwarding = 1'b1;
    id_wb_enable = 1'b1; id_dest = 4'd5; id_is_load = 1'b1;
    tick();
    id_wb_enable = 1'b0; id_is_load = 1'b0; src2 = 4'd5; two_src = 1'b1;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL fwd_loaduse got %b exp 1", hazard); end
    tick();
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL fwd_loaduse_clear got %b exp 0", hazard); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL fwd_loaduse_count got %0d exp 1", stall_count); end
    // src2 not a real operand: no stall.
    do_reset();
    forwarding = 1'b1;
    id_wb_enable = 1'b1; id_dest = 4'd5; id_is_load = 1'b1;
    tick();
    id_wb_enable = 1'b0; id_is_load = 1'b0; src2 = 4'd5; two_src = 1'b0;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL fwd_one_src got %b exp 0", hazard); end
    tick();
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL fwd_one_src_count got %0d exp 0", stall_count); end
    // ALU producer is forwarded: no stall.
    do_reset();
    forwarding = 1'b1;
    id_wb_enable = 1'b1; id_dest = 4'd5; id_is_load = 1'b0;
    tick();
    id_wb_enable = 1'b0; src2 = 4'd5; two_src = 1'b1;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL fwd_alu got %b exp 0", hazard); end
    // Same entries, forwarding switched off: stall immediately.
    forwarding = 1'b0;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL fwd_toggle got %b exp 1", hazard); end
    forwarding = 1'b1;
  endtask

  task automatic test_freeze;
    do_reset();
    forwarding = 1'b1;
    id_wb_enable = 1'b1; id_dest = 4'd5; id_is_load = 1'b1;
    tick();
    id_wb_enable = 1'b0; id_is_load = 1'b0; src1 = 4'd5; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL freeze_hazard%0d got %b exp 1", i, hazard); end
      tick();
    end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL freeze_count got %0d exp 0", stall_count); end
    mem_ready = 1'b1;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL freeze_release got %b exp 1", hazard); end
    tick();
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL freeze_advance got %b exp 0", hazard); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL freeze_count_after got %0d exp 1", stall_count); end
  endtask

  task automatic test_flush;
    do_reset();
    forwarding = 1'b0;
    id_wb_enable = 1'b1; id_dest = 4'd3;
    tick();
    id_dest = 4'd9; src1 = 4'd3; flush = 1'b1;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL flush_hazard got %b exp 0", hazard); end
    tick();
    flush = 1'b0; id_wb_enable = 1'b0; src1 = 4'd9;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL flush_bubble got %b exp 0", hazard); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", stall_count); end
    src1 = 4'd3;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL flush_older got %b exp 1", hazard); end
  endtask

  task automatic run_raw(input logic [3:0] r);
    src1 = 4'd0; id_wb_enable = 1'b1; id_dest = r;
    tick();
    id_wb_enable = 1'b0; src1 = r;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!hazard) break;
      tick();
    end
    src1 = 4'd0;
  endtask

  task automatic test_saturate;
    do_reset();
    forwarding = 1'b0;
    run_raw(4'd3);
    checks++; if (stall_count_s !== 2'd3) begin errors++; $display("FAIL sat_first got %0d exp 3", stall_count_s); end
    run_raw(4'd6);
    checks++; if (stall_count_s !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", stall_count_s); end
    checks++; if (stall_count !== 16'd6) begin errors++; $display("FAIL sat_wide got %0d exp 6", stall_count); end
  endtask

  task automatic test_async_rst;
    do_reset();
    forwarding = 1'b0;
    id_wb_enable = 1'b1; id_dest = 4'd7;
    tick();
    id_wb_enable = 1'b0; src1 = 4'd7;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL arst_before got %b exp 1", hazard); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL arst_immediate got %b exp 0", hazard); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL arst_after got %b exp 0", hazard); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", stall_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    forwarding = 1'b0;
    set_idle();
    test_reset();
    test_no_fwd();
    test_fwd();
    test_freeze();
    test_flush();
    test_saturate();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
